fp_issue_arbiter: RTL and testbench
===================================

# fp_issue_arbiter

Two-requester issue arbiter and response router in front of `fp_wrapper`. It shares the single FP datapath between two instruction sources (e.g. two harts, or a core plus a DMA/test sequencer) with round-robin fairness and per-requester outstanding-operation limits. The requester ID travels through the datapath tag so each result returns to the requester that issued it. It also sequences a global flush and gives instructions the datapath rejects as illegal their own in-order response.

## Interface
- `INSTR_W`, 32, instruction width
- `DATA_W`, 32, result width
- `MAX_OUT`, 4, max in-flight ops per requester (≥1); counter width `$clog2(MAX_OUT+1)`

Ports:
- `clk_i`  in  1  clock, all state on rising edge
- `rst_i`  in  1  reset, asynchronous, active-high
- `req_valid_i`  in  2  per-requester issue valid
- `req_ready_o`  out  2  per-requester issue accept
- `req_instr_i`  in  2×INSTR_W  per-requester instruction
- `rsp_valid_o`  out  2  per-requester response valid
- `rsp_ready_i`  in  2  per-requester response accept
- `rsp_result_o`  out  2×DATA_W  per-requester result
- `rsp_illegal_o`  out  2  response is an illegal-instruction completion
- `flush_i`  in  1  single-cycle flush request
- `busy_o`  out  1  any op in flight, pending or held
- `fpu_instr_o`  out  INSTR_W  to `fp_wrapper` `instr_i`
- `fpu_in_valid_o`  out  1  to `in_valid_i`
- `fpu_in_ready_i`  in  1  from `in_ready_o`
- `fpu_tag_o`  out  1  requester ID to tag input
- `fpu_illegal_i`  in  1  from `illegal_insn`, combinational on presented instr
- `fpu_result_i`  in  DATA_W  from `result_o`
- `fpu_tag_i`  in  1  from `tag_o`
- `fpu_out_valid_i`  in  1  from `out_valid_o`
- `fpu_out_ready_o`  out  1  to `out_ready_i`
- `fpu_flush_o`  out  1  to `flush_i`

## Operation
- FSM: `ARB`, `HOLD`, `FLUSH`. Reset → `ARB`; RR pointer favours requester 0; counters 0; illegal slots empty; all outputs 0.
- Requester r is eligible when `req_valid_i[r]`, `cnt[r] < MAX_OUT` and `slot[r]` is empty.
- `ARB`:
  - Pick an eligible requester by RR pointer, grant g.
  - Drive `fpu_in_valid_o=1`, `fpu_instr_o=req_instr_i[g]`, `fpu_tag_o=g`, `req_ready_o[g]=fpu_in_ready_i`.
  - Not accepted → `HOLD` with g registered.
- `HOLD`: grant locked to g; same drive as `ARB`; back to `ARB` on accept. Requesters keep valid/instr stable until ready.
- Accept when `fpu_in_valid_o && fpu_in_ready_i`:
  - `cnt[g]++`.
  - RR pointer moves to the other requester.
- Illegal: if `fpu_illegal_i` is high in the accept cycle, `cnt[g]` is not incremented; `slot[g]` is set instead.
- Slot delivery: `slot[r]` is presented as a response (`rsp_illegal_o[r]=1`, result 0) only when `cnt[r]==0`. This preserves per-requester order. The slot clears on `rsp_ready_i[r]`.
- Response routing:
  - `rsp_valid_o[fpu_tag_i] = fpu_out_valid_i`, with result passed through.
  - `fpu_out_ready_o = rsp_ready_i[fpu_tag_i]`.
  - On handshake, `cnt[tag]--`.
  - An increment and a decrement on the same counter in one cycle leave it unchanged.
- Concurrency: an FPU response for one requester and a slot delivery for the other are presented in the same cycle independently. A slot and an FPU response cannot coexist for the same requester.
- `FLUSH`:
  - Entered from any state when `flush_i=1`. That cycle, issue is suppressed (`fpu_in_valid_o=0`, `req_ready_o=0`).
  - Next cycle: `fpu_flush_o=1`, `fpu_out_ready_o=1`, all `rsp_valid_o=0`; responses arriving this cycle are dropped.
  - Exit to `ARB`: counters cleared, slots cleared, RR pointer kept.
- `busy_o`: any `cnt≠0`, any slot full, `fpu_in_valid_o`, or state `FLUSH`.
- Counter overflow/underflow is impossible by construction. A decrement at 0, e.g. a stray tag, is ignored.

## Timing
- Issue: combinational, 0 cycles from `req_valid_i` to `fpu_in_valid_o` when idle and eligible.
- Response: combinational pass-through, 0 cycles.
- Illegal response: earliest 1 cycle after the accept cycle, gated on `cnt==0`.
- Flush: `fpu_flush_o` high exactly 1 cycle, starting 1 cycle after `flush_i`; issue resumes the following cycle.
- Reset asserted mid-operation: immediate return to the reset state; the in-flight FPU result is discarded.
- Both requesters valid every cycle with the FPU always ready: grants alternate 0,1,0,1.

## Test plan
- Both requesters valid, `in_ready` tied 1, `MAX_OUT=4`, 8 issues → grants 0,1,0,1,…; each result returns with the matching tag to the correct `rsp_valid_o`.
- Requester 0 issues 4 ops with no responses → `cnt[0]=4`, `req_ready_o[0]=0`; requester 1 is still granted. One response for requester 0 → requester 0 is eligible the next cycle.
- `in_ready` low for 3 cycles while requester 0 is granted and requester 1 asserts valid → grant held on 0 (`HOLD`), instr stable; requester 1 is granted only after 0 is accepted.
- Requester 1 has 2 ops outstanding, then an illegal instr is accepted → no `rsp_illegal_o[1]` until both results are returned; then `rsp_illegal_o[1]=1`, result 0.
- `flush_i` pulse with 3 ops in flight and a pending issue → no accept that cycle; `fpu_flush_o=1` next cycle; counters 0; a late `out_valid` in the flush cycle is dropped.
- `rst_i` asserted while in `HOLD` with `cnt=2` → all outputs 0 at once, state `ARB`, RR pointer favours requester 0.

Source files
------------

// File: rtl/fp_issue_arbiter.sv
// Two-requester round-robin issue arbiter and response router in front of fp_wrapper.
// Tracks per-requester outstanding ops, returns illegal-instruction completions in order, sequences flush.
module fp_issue_arbiter #(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [1:0]           req_valid_i,
  output logic [1:0]           req_ready_o,
  input  logic [2*INSTR_W-1:0] req_instr_i,
  output logic [1:0]           rsp_valid_o,
  input  logic [1:0]           rsp_ready_i,
  output logic [2*DATA_W-1:0]  rsp_result_o,
  output logic [1:0]           rsp_illegal_o,
  input  logic                 flush_i,
  output logic                 busy_o,
  output logic [INSTR_W-1:0]   fpu_instr_o,
  output logic                 fpu_in_valid_o,
  input  logic                 fpu_in_ready_i,
  output logic                 fpu_tag_o,
  input  logic                 fpu_illegal_i,
  input  logic [DATA_W-1:0]    fpu_result_i,
  input  logic                 fpu_tag_i,
  input  logic                 fpu_out_valid_i,
  output logic                 fpu_out_ready_o,
  output logic                 fpu_flush_o
);

  localparam int unsigned CntW = $clog2(MAX_OUT + 1);

  typedef enum logic [1:0] {StArb, StHold, StFlush} state_e;

  state_e                 state_q, state_d;
  logic                   rr_q, rr_d;
  logic                   hold_g_q, hold_g_d;
  logic [1:0][CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]             slot_q, slot_d;

  logic [1:0][INSTR_W-1:0] instr_arr;
  logic [1:0][DATA_W-1:0]  res_arr;
  logic [1:0]              eligible;
  logic [1:0]              slot_deliver;
  logic                    issue, g, accept, in_flush, rsp_fire, inc, dec;

  assign instr_arr    = req_instr_i;
  assign rsp_result_o = res_arr;
  assign in_flush     = (state_q == StFlush);

  always_comb begin
    for (int r = 0; r < 2; r++) begin
      eligible[r]     = req_valid_i[r] && (cnt_q[r] < CntW'(MAX_OUT)) && !slot_q[r];
      slot_deliver[r] = slot_q[r] && (cnt_q[r] == '0) && !in_flush;
    end

    issue = 1'b0;
    g     = rr_q;
    unique case (state_q)
      StArb: begin
        if (eligible[rr_q]) begin
          issue = 1'b1;
          g     = rr_q;
        end else if (eligible[~rr_q]) begin
          issue = 1'b1;
          g     = ~rr_q;
        end
      end
      StHold: begin
        issue = 1'b1;
        g     = hold_g_q;
      end
      default: issue = 1'b0;
    endcase
    if (flush_i) issue = 1'b0;

    accept         = issue && fpu_in_ready_i;
    fpu_in_valid_o = issue;
    fpu_instr_o    = issue ? instr_arr[g] : '0;
    fpu_tag_o      = issue & g;
    req_ready_o    = 2'b00;
    if (issue) req_ready_o[g] = fpu_in_ready_i;

    // FPU response routed by tag; an illegal slot can only be shown when its counter is 0
    rsp_valid_o   = 2'b00;
    rsp_illegal_o = 2'b00;
    res_arr       = '0;
    if (!in_flush && fpu_out_valid_i) begin
      rsp_valid_o[fpu_tag_i] = 1'b1;
      res_arr[fpu_tag_i]     = fpu_result_i;
    end
    for (int r = 0; r < 2; r++) begin
      if (slot_deliver[r]) begin
        rsp_valid_o[r]   = 1'b1;
        rsp_illegal_o[r] = 1'b1;
        res_arr[r]       = '0;
      end
    end
    fpu_out_ready_o = in_flush ? 1'b1 : rsp_ready_i[fpu_tag_i];
    fpu_flush_o     = in_flush;
    rsp_fire        = !in_flush && fpu_out_valid_i && fpu_out_ready_o;

    cnt_d  = cnt_q;
    slot_d = slot_q;
    for (int r = 0; r < 2; r++) begin
      inc = accept && (g == 1'(r)) && !fpu_illegal_i;
      dec = rsp_fire && (fpu_tag_i == 1'(r)) && (cnt_q[r] != '0);
      if (inc && !dec) cnt_d[r] = cnt_q[r] + CntW'(1);
      else if (dec && !inc) cnt_d[r] = cnt_q[r] - CntW'(1);
      if (accept && (g == 1'(r)) && fpu_illegal_i) slot_d[r] = 1'b1;
      else if (slot_deliver[r] && rsp_ready_i[r]) slot_d[r] = 1'b0;
    end

    rr_d     = accept ? ~g : rr_q;
    hold_g_d = hold_g_q;
    state_d  = state_q;
    unique case (state_q)
      StArb: begin
        if (issue && !fpu_in_ready_i) begin
          state_d  = StHold;
          hold_g_d = g;
        end
      end
      StHold: if (accept) state_d = StArb;
      StFlush: begin
        state_d = StArb;
        cnt_d   = '0;
        slot_d  = '0;
      end
      default: state_d = StArb;
    endcase
    if (flush_i) state_d = StFlush;

    busy_o = (cnt_q[0] != '0) || (cnt_q[1] != '0) || (|slot_q) || issue || in_flush;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StArb;
      rr_q     <= 1'b0;
      hold_g_q <= 1'b0;
      cnt_q    <= '0;
      slot_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      hold_g_q <= hold_g_d;
      cnt_q    <= cnt_d;
      slot_q   <= slot_d;
    end
  end

endmodule

// File: tb/tb_fp_issue_arbiter.sv
// Self-checking bench for fp_issue_arbiter: a small in-order FPU model plus a scoreboard of
// expected {requester, result} pairs pushed at issue and popped at response delivery.
module tb_fp_issue_arbiter;

  localparam int unsigned IW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MO = 4;
  localparam logic [31:0] K  = 32'h5A5A_0F0F;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [1:0]    req_valid_i = '0;
  logic [1:0]    req_ready_o;
  logic [2*IW-1:0] req_instr_i;
  logic [1:0]    rsp_valid_o;
  logic [1:0]    rsp_ready_i = '0;
  logic [2*DW-1:0] rsp_result_o;
  logic [1:0]    rsp_illegal_o;
  logic          flush_i = 1'b0;
  logic          busy_o;
  logic [IW-1:0] fpu_instr_o;
  logic          fpu_in_valid_o;
  logic          fpu_in_ready_i = 1'b0;
  logic          fpu_tag_o;
  logic          fpu_illegal_i = 1'b0;
  logic [DW-1:0] fpu_result_i = '0;
  logic          fpu_tag_i = 1'b0;
  logic          fpu_out_valid_i = 1'b0;
  logic          fpu_out_ready_o;
  logic          fpu_flush_o;

  logic [31:0] instr_r0 = 32'h1111_0000;
  logic [31:0] instr_r1 = 32'h2222_0000;
  assign req_instr_i = {instr_r1, instr_r0};

  fp_issue_arbiter #(.INSTR_W(IW), .DATA_W(DW), .MAX_OUT(MO)) u_dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_instr_i    (req_instr_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_result_o   (rsp_result_o),
    .rsp_illegal_o  (rsp_illegal_o),
    .flush_i        (flush_i),
    .busy_o         (busy_o),
    .fpu_instr_o    (fpu_instr_o),
    .fpu_in_valid_o (fpu_in_valid_o),
    .fpu_in_ready_i (fpu_in_ready_i),
    .fpu_tag_o      (fpu_tag_o),
    .fpu_illegal_i  (fpu_illegal_i),
    .fpu_result_i   (fpu_result_i),
    .fpu_tag_i      (fpu_tag_i),
    .fpu_out_valid_i(fpu_out_valid_i),
    .fpu_out_ready_o(fpu_out_ready_o),
    .fpu_flush_o    (fpu_flush_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        r;
    logic [31:0] res;
  } exp_t;

  exp_t exp_q[$];
  exp_t fpu_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ret_budget = 0;
  logic exp_g = 1'b0;
  logic found;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // FPU model presents its oldest op while it still has a return budget
  task automatic settle();
    if (fpu_q.size() > 0 && ret_budget > 0) begin
      fpu_out_valid_i = 1'b1;
      fpu_tag_i       = fpu_q[0].r;
      fpu_result_i    = fpu_q[0].res;
    end else begin
      fpu_out_valid_i = 1'b0;
      fpu_tag_i       = 1'b0;
      fpu_result_i    = '0;
    end
    #1;
  endtask

  task automatic advance();
    logic acc, pop;
    exp_t e;
    acc = fpu_in_valid_o && fpu_in_ready_i;
    pop = fpu_out_valid_i && fpu_out_ready_o;
    if (acc) check_eq("grant", 64'(fpu_tag_o), 64'(exp_g));
    for (int r = 0; r < 2; r++) begin
      if (rsp_valid_o[r] && rsp_ready_i[r] && !rsp_illegal_o[r]) begin
        check_eq("rsp_pending", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("rsp_req", 64'(r), 64'(e.r));
          check_eq("rsp_res", 64'(rsp_result_o[r*DW +: DW]), 64'(e.res));
        end
      end
    end
    if (pop) begin
      void'(fpu_q.pop_front());
      ret_budget--;
    end
    if (acc && !fpu_illegal_i) begin
      fpu_q.push_back('{r: fpu_tag_o, res: fpu_instr_o ^ K});
      exp_q.push_back('{r: exp_g, res: (exp_g ? instr_r1 : instr_r0) ^ K});
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic bump_instr(input logic r);
    if (r) instr_r1 = $urandom;
    else instr_r0 = $urandom;
  endtask

  task automatic drain(input string tag);
    ret_budget = 1000;
    rsp_ready_i = 2'b11;
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
      settle();
      advance();
    end
    check_eq(tag, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_busy"}, 64'(busy_o), 64'd0);
    check_eq({tag, "_in_valid"}, 64'(fpu_in_valid_o), 64'd0);
    check_eq({tag, "_req_ready"}, 64'(req_ready_o), 64'd0);
    check_eq({tag, "_rsp_valid"}, 64'(rsp_valid_o), 64'd0);
    check_eq({tag, "_flush"}, 64'(fpu_flush_o), 64'd0);
  endtask

  task automatic do_reset();
    req_valid_i = '0;
    flush_i = 1'b0;
    fpu_in_ready_i = 1'b0;
    fpu_illegal_i = 1'b0;
    rsp_ready_i = '0;
    ret_budget = 0;
    fpu_out_valid_i = 1'b0;
    fpu_tag_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    check_quiet("rst");
    fpu_q.delete();
    exp_q.delete();
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    @(negedge clk_i);

    // Alternating grants with both requesters always valid
    do_reset();
    rsp_ready_i = 2'b11;
    fpu_in_ready_i = 1'b1;
    ret_budget = 1000;
    instr_r0 = $urandom;
    instr_r1 = $urandom;
    req_valid_i = 2'b11;
    for (int i = 0; i < 8; i++) begin
      exp_g = (i % 2 == 1);
      settle();
      check_eq("t1_tag", 64'(fpu_tag_o), 64'(exp_g));
      advance();
      bump_instr(exp_g);
    end
    req_valid_i = 2'b00;
    drain("t1_drain");
    settle();
    check_eq("t1_idle_busy", 64'(busy_o), 64'd0);
    advance();

    // Outstanding limit on requester 0; requester 1 still served
    do_reset();
    fpu_in_ready_i = 1'b1;
    rsp_ready_i = 2'b11;
    req_valid_i = 2'b01;
    exp_g = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      check_eq("t2_issue", 64'(fpu_in_valid_o), 64'd1);
      advance();
      bump_instr(1'b0);
    end
    settle();
    check_eq("t2_full_ready", 64'(req_ready_o[0]), 64'd0);
    check_eq("t2_full_valid", 64'(fpu_in_valid_o), 64'd0);
    advance();
    req_valid_i = 2'b11;
    exp_g = 1'b1;
    settle();
    check_eq("t2_r1_tag", 64'(fpu_tag_o), 64'd1);
    check_eq("t2_r1_valid", 64'(fpu_in_valid_o), 64'd1);
    advance();
    bump_instr(1'b1);
    req_valid_i = 2'b01;
    exp_g = 1'b0;
    ret_budget = 1;
    settle();
    check_eq("t2_still_full", 64'(fpu_in_valid_o), 64'd0);
    advance();
    settle();
    check_eq("t2_reissue_valid", 64'(fpu_in_valid_o), 64'd1);
    check_eq("t2_reissue_tag", 64'(fpu_tag_o), 64'd0);
    advance();
    req_valid_i = 2'b00;
    drain("t2_drain");

    // HOLD: grant locked on 0 while the FPU stalls
    do_reset();
    rsp_ready_i = 2'b11;
    ret_budget = 1000;
    fpu_in_ready_i = 1'b0;
    req_valid_i = 2'b11;
    exp_g = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check_eq("t3_hold_tag", 64'(fpu_tag_o), 64'd0);
      check_eq("t3_hold_valid", 64'(fpu_in_valid_o), 64'd1);
      check_eq("t3_hold_instr", 64'(fpu_instr_o), 64'(instr_r0));
      check_eq("t3_hold_ready", 64'(req_ready_o), 64'd0);
      advance();
    end
    fpu_in_ready_i = 1'b1;
    settle();
    check_eq("t3_accept_ready", 64'(req_ready_o), 64'd1);
    advance();
    bump_instr(1'b0);
    req_valid_i = 2'b10;
    exp_g = 1'b1;
    settle();
    check_eq("t3_r1_tag", 64'(fpu_tag_o), 64'd1);
    advance();
    req_valid_i = 2'b00;
    drain("t3_drain");

    // Illegal completion waits behind outstanding results
    do_reset();
    rsp_ready_i = 2'b11;
    fpu_in_ready_i = 1'b1;
    req_valid_i = 2'b10;
    exp_g = 1'b1;
    for (int i = 0; i < 2; i++) begin
      settle();
      advance();
      bump_instr(1'b1);
    end
    fpu_illegal_i = 1'b1;
    settle();
    check_eq("t4_illegal_accept", 64'(req_ready_o), 64'd2);
    advance();
    fpu_illegal_i = 1'b0;
    req_valid_i = 2'b00;
    for (int i = 0; i < 2; i++) begin
      settle();
      check_eq("t4_early_illegal", 64'(rsp_illegal_o), 64'd0);
      check_eq("t4_early_valid", 64'(rsp_valid_o), 64'd0);
      advance();
    end
    ret_budget = 2;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      settle();
      if (rsp_illegal_o[1]) begin
        found = 1'b1;
        check_eq("t4_order", 64'(exp_q.size()), 64'd0);
        check_eq("t4_valid", 64'(rsp_valid_o), 64'd2);
        check_eq("t4_result", 64'(rsp_result_o[DW +: DW]), 64'd0);
      end
      advance();
    end
    check_eq("t4_seen", 64'(found), 64'd1);
    settle();
    check_eq("t4_cleared", 64'(rsp_illegal_o), 64'd0);
    check_eq("t4_busy", 64'(busy_o), 64'd0);
    advance();

    // Flush with three ops in flight and a pending issue
    do_reset();
    rsp_ready_i = 2'b11;
    fpu_in_ready_i = 1'b1;
    req_valid_i = 2'b11;
    for (int i = 0; i < 3; i++) begin
      exp_g = (i % 2 == 1);
      settle();
      advance();
      bump_instr(exp_g);
    end
    req_valid_i = 2'b01;
    flush_i = 1'b1;
    settle();
    check_eq("t5_noissue", 64'(fpu_in_valid_o), 64'd0);
    check_eq("t5_noready", 64'(req_ready_o), 64'd0);
    advance();
    flush_i = 1'b0;
    req_valid_i = 2'b00;
    ret_budget = 1;
    settle();
    check_eq("t5_flush", 64'(fpu_flush_o), 64'd1);
    check_eq("t5_out_ready", 64'(fpu_out_ready_o), 64'd1);
    check_eq("t5_drop", 64'(rsp_valid_o), 64'd0);
    check_eq("t5_flush_noissue", 64'(fpu_in_valid_o), 64'd0);
    advance();
    fpu_q.delete();
    exp_q.delete();
    ret_budget = 0;
    settle();
    check_eq("t5_flush_once", 64'(fpu_flush_o), 64'd0);
    check_eq("t5_cnt_clear", 64'(busy_o), 64'd0);
    advance();
    req_valid_i = 2'b01;
    exp_g = 1'b0;
    settle();
    check_eq("t5_resume", 64'(fpu_in_valid_o), 64'd1);
    advance();
    req_valid_i = 2'b00;
    drain("t5_drain");

    // Reset while holding with two ops outstanding
    do_reset();
    fpu_in_ready_i = 1'b1;
    rsp_ready_i = 2'b11;
    req_valid_i = 2'b01;
    exp_g = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      advance();
      bump_instr(1'b0);
    end
    fpu_in_ready_i = 1'b0;
    req_valid_i = 2'b11;
    exp_g = 1'b1;
    settle();
    check_eq("t6_pre_tag", 64'(fpu_tag_o), 64'd1);
    advance();
    settle();
    check_eq("t6_hold_valid", 64'(fpu_in_valid_o), 64'd1);
    #2;
    rst_i = 1'b1;
    req_valid_i = 2'b00;
    #1;
    check_quiet("t6_rst");
    fpu_q.delete();
    exp_q.delete();
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    req_valid_i = 2'b11;
    fpu_in_ready_i = 1'b1;
    exp_g = 1'b0;
    settle();
    check_eq("t6_rr_reset", 64'(fpu_tag_o), 64'd0);
    advance();
    req_valid_i = 2'b00;
    drain("t6_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
